hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage MIPS core: parametrised successor of the combinational hazard unit. Generates E-stage and D-stage forwarding selects, load-use and branch stalls, multi-cycle multiply/divide occupancy stalls via an internal state machine, and precise exception flushes. It sits beside the datapath, driving stall/flush enables of the F/D, D/E, E/M and M/W pipeline registers.

---
 rtl/hazard_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use/branch/mul-div stalls, exception flushes (optional macro HAZARD_FWD_W2D_EN adds W->D forwarding).
// Outputs are combinational from inputs and state (no added latency); a mul/div holds F/D/E for N-1 cycles so it occupies E for exactly N cycles.
module hazard_ctrl #(
    parameter int RA_W       = 5,
    parameter int DIV_CYCLES = 36,
    parameter int MUL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] rsD,
    input  logic [RA_W-1:0] rtD,
    input  logic            branchD,
    input  logic [RA_W-1:0] rsE,
    input  logic [RA_W-1:0] rtE,
    input  logic [RA_W-1:0] writeregE,
    input  logic            regwriteE,
    input  logic            memtoregE,
    input  logic [RA_W-1:0] writeregM,
    input  logic            regwriteM,
    input  logic            memtoregM,
    input  logic [RA_W-1:0] writeregW,
    input  logic            regwriteW,
    input  logic            mdstartE,
    input  logic            mdopE,
    input  logic            exceptM,
    output logic [1:0]      forwardaD,
    output logic [1:0]      forwardbD,
    output logic [1:0]      forwardaE,
    output logic [1:0]      forwardbE,
    output logic            stallF,
    output logic            stallD,
    output logic            stallE,
    output logic            flushD,
    output logic            flushE,
    output logic            flushM,
    output logic            flushW,
    output logic            mdbusy
);

    localparam int MAXC  = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    // Counter holds the number of BUSY cycles still to come after the current one.
    localparam logic [CNT_W-1:0] DIV_LOAD = (DIV_CYCLES >= 3) ? CNT_W'(DIV_CYCLES - 3) : '0;
    localparam logic [CNT_W-1:0] MUL_LOAD = (MUL_CYCLES >= 3) ? CNT_W'(MUL_CYCLES - 3) : '0;
    localparam logic DIV_LONG = (DIV_CYCLES >= 2);
    localparam logic MUL_LONG = (MUL_CYCLES >= 2);
    localparam logic DIV_TWO  = (DIV_CYCLES == 2);
    localparam logic MUL_TWO  = (MUL_CYCLES == 2);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;

    logic md_long, md_two, md_go, mdstall;
    logic lwstall, brstall;

    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] src,
        input logic [RA_W-1:0] m_reg,
        input logic            m_we,
        input logic [RA_W-1:0] w_reg,
        input logic            w_we
    );
        if (src != '0 && m_we && src == m_reg) begin
            return 2'b10;
        end else if (src != '0 && w_we && src == w_reg) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign md_long = mdopE ? DIV_LONG : MUL_LONG;
    assign md_two  = mdopE ? DIV_TWO  : MUL_TWO;
    assign md_go   = (state_q == IDLE) && mdstartE && md_long;
    assign mdstall = md_go || (state_q == BUSY);

    assign lwstall = memtoregE && writeregE != '0 &&
                     (writeregE == rsD || writeregE == rtD);
    assign brstall = branchD &&
                     ((regwriteE && writeregE != '0 && (writeregE == rsD || writeregE == rtD)) ||
                      (memtoregM && writeregM != '0 && (writeregM == rsD || writeregM == rtD)));

    // A two-cycle op skips BUSY: DONE alone masks the still-held mdstartE.
    always_ff @(posedge clk) begin
        if (rst || exceptM) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (md_go) begin
                        if (md_two) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= mdopE ? DIV_LOAD : MUL_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        forwardaE = 2'b00;
        forwardbE = 2'b00;
        forwardaD = 2'b00;
        forwardbD = 2'b00;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushM    = 1'b0;
        flushW    = 1'b0;
        mdbusy    = 1'b0;
        if (rst) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else begin
            forwardaE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
            forwardbE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
`ifdef HAZARD_FWD_W2D_EN
            forwardaD = fwd_sel(rsD, writeregM, regwriteM, writeregW, regwriteW);
            forwardbD = fwd_sel(rtD, writeregM, regwriteM, writeregW, regwriteW);
`else
            forwardaD = fwd_sel(rsD, writeregM, regwriteM, writeregW, 1'b0);
            forwardbD = fwd_sel(rtD, writeregM, regwriteM, writeregW, 1'b0);
`endif
            mdbusy = (state_q == BUSY);
            if (exceptM) begin
                flushD = 1'b1;
                flushE = 1'b1;
                flushM = 1'b1;
                flushW = 1'b1;
            end else if (mdstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (lwstall || brstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

endmodule
